// File: rtl/unpool_pkg.sv
// Shared helpers for the unpooling stage: ceil-log2, fixed-point width
// derivation and the packed-unit slicing macro used by the layer blocks.
`define UNPOOL_UNIT(vec, u, w) vec[(u)*(w) +: (w)]

package unpool_pkg;

  function automatic int log2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int fixed_bitw(input int int_bitw, input int frac_bitw);
    return int_bitw + frac_bitw;
  endfunction

endpackage

// File: rtl/unpool_buf.sv
// Simple dual-port line bank: one write port, one read port with a
// registered read. One instance holds one block row of pooled samples.
module unpool_buf
  import unpool_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int BIT_WIDTH = 13,
  localparam int ADDR_BITW = (DEPTH > 1) ? log2(DEPTH) : 1
) (
  input  logic                   clock,
  input  logic                   wr_en,
  input  logic [ADDR_BITW-1:0]   wr_addr,
  input  logic [0:BIT_WIDTH-1]   wr_data,
  input  logic [ADDR_BITW-1:0]   rd_addr,
  output logic [0:BIT_WIDTH-1]   rd_data
);

  logic [0:BIT_WIDTH-1] mem_q [DEPTH];
  logic [0:BIT_WIDTH-1] rd_data_q;

  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/unpool.sv
// Nearest-neighbour 2x2 unpooling: stores each pooled block row in a
// ping-pong bank and replays it on both output rows two input rows later.
module unpool
  import unpool_pkg::*;
#(
  parameter int HEIGHT    = 4,
  parameter int WIDTH     = 8,
  parameter int W_HEIGHT  = 7,
  parameter int W_WIDTH   = 10,
  parameter int UNITS     = 12,
  parameter int INT_BITW  = 5,
  parameter int FRAC_BITW = 8,
  localparam int FIXED_BITW = fixed_bitw(INT_BITW, FRAC_BITW),
  localparam int PIX_BITW   = FIXED_BITW * UNITS,
  localparam int V_BITW     = log2(W_HEIGHT),
  localparam int H_BITW     = log2(W_WIDTH)
) (
  input  logic                clock,
  input  logic                n_rst,
  input  logic                in_enable,
  input  logic [0:PIX_BITW-1] in_pixels,
  input  logic [V_BITW-1:0]   in_vcnt,
  input  logic [H_BITW-1:0]   in_hcnt,
  output logic                out_enable,
  output logic [0:PIX_BITW-1] out_pixels,
  output logic [V_BITW-1:0]   out_vcnt,
  output logic [H_BITW-1:0]   out_hcnt
);

  localparam int DEPTH     = WIDTH / 2;
  localparam int ADDR_BITW = (DEPTH > 1) ? log2(DEPTH) : 1;

  localparam logic [V_BITW-1:0]    HEIGHT_V   = V_BITW'(HEIGHT);
  localparam logic [V_BITW-1:0]    V_WRAP     = V_BITW'(W_HEIGHT - 2);
  localparam logic [V_BITW-1:0]    V_TWO      = V_BITW'(2);
  localparam logic [H_BITW-1:0]    WIDTH_H    = H_BITW'(WIDTH);
  localparam logic [ADDR_BITW-1:0] LAST_ADDR  = ADDR_BITW'(DEPTH - 1);

  logic                 wr_en;
  logic                 wr_bank;
  logic [ADDR_BITW-1:0] wr_addr;
  logic [ADDR_BITW-1:0] rd_addr;
  logic [V_BITW-1:0]    vo;
  logic                 rd_bank;
  logic                 h_active;

  logic [1:0]        armed_d, armed_q;
  logic [1:0]        valid_d, valid_q;
  logic              rd_bank_d, rd_bank_q;
  logic              out_enable_d, out_enable_q;
  logic [V_BITW-1:0] out_vcnt_d, out_vcnt_q;
  logic [H_BITW-1:0] out_hcnt_d, out_hcnt_q;

  logic [0:PIX_BITW-1] rd_data [2];

  always_comb begin
    h_active = (in_hcnt < WIDTH_H);
    wr_en    = in_enable & in_vcnt[0] & in_hcnt[0] & (in_vcnt < HEIGHT_V) & h_active;
    wr_bank  = in_vcnt[1];
    wr_addr  = ADDR_BITW'(in_hcnt >> 1);

    // Output raster trails the input raster by two rows, wrapping through blanking.
    vo      = (in_vcnt < V_TWO) ? (in_vcnt + V_WRAP) : (in_vcnt - V_TWO);
    rd_bank = vo[1];
    rd_addr = h_active ? ADDR_BITW'(in_hcnt >> 1) : '0;
  end

  always_comb begin
    armed_d = armed_q;
    valid_d = valid_q;
    if (wr_en && (wr_addr == '0)) armed_d[wr_bank] = 1'b1;
    // A bank only becomes readable once a whole row was written after reset.
    if (wr_en && (wr_addr == LAST_ADDR) && armed_q[wr_bank]) valid_d[wr_bank] = 1'b1;

    rd_bank_d    = rd_bank;
    out_enable_d = (vo < HEIGHT_V) & h_active & valid_q[rd_bank];
    out_vcnt_d   = vo;
    out_hcnt_d   = in_hcnt;
  end

  always_ff @(posedge clock) begin
    if (n_rst) begin
      armed_q      <= '0;
      valid_q      <= '0;
      rd_bank_q    <= 1'b0;
      out_enable_q <= 1'b0;
      out_vcnt_q   <= '0;
      out_hcnt_q   <= '0;
    end else begin
      armed_q      <= armed_d;
      valid_q      <= valid_d;
      rd_bank_q    <= rd_bank_d;
      out_enable_q <= out_enable_d;
      out_vcnt_q   <= out_vcnt_d;
      out_hcnt_q   <= out_hcnt_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    unpool_buf #(
      .DEPTH     (DEPTH),
      .BIT_WIDTH (PIX_BITW)
    ) u_buf (
      .clock   (clock),
      .wr_en   (wr_en && (wr_bank == 1'(b))),
      .wr_addr (wr_addr),
      .wr_data (in_pixels),
      .rd_addr (rd_addr),
      .rd_data (rd_data[b])
    );
  end

  assign out_enable = out_enable_q;
  assign out_pixels = out_enable_q ? rd_data[rd_bank_q] : '0;
  assign out_vcnt   = out_vcnt_q;
  assign out_hcnt   = out_hcnt_q;

endmodule

// File: tb/tb_unpool.sv
// Directed bench for unpool on an 8x4 active / 10x7 raster, one unit per pixel.
module tb_unpool;

  localparam int PW = 13;

  logic          clock = 1'b0;
  logic          n_rst = 1'b1;
  logic          in_enable = 1'b0;
  logic [0:PW-1] in_pixels = '0;
  logic [2:0]    in_vcnt = '0;
  logic [3:0]    in_hcnt = '0;
  logic          out_enable;
  logic [0:PW-1] out_pixels;
  logic [2:0]    out_vcnt;
  logic [3:0]    out_hcnt;

  unpool #(
    .HEIGHT(4), .WIDTH(8), .W_HEIGHT(7), .W_WIDTH(10),
    .UNITS(1), .INT_BITW(5), .FRAC_BITW(8)
  ) dut (
    .clock(clock), .n_rst(n_rst), .in_enable(in_enable), .in_pixels(in_pixels),
    .in_vcnt(in_vcnt), .in_hcnt(in_hcnt), .out_enable(out_enable),
    .out_pixels(out_pixels), .out_vcnt(out_vcnt), .out_hcnt(out_hcnt)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int vc = 0, hc = 0, pv = 0, ph = 0;
  logic          o_en;
  logic [PW-1:0] o_pix;
  logic [2:0]    o_v;
  logic [3:0]    o_h;

  function automatic logic [PW-1:0] word(input int i, input int j, input int tag);
    return PW'((i << 8) | j | tag);
  endfunction

  function automatic logic [PW-1:0] src(input int tag);
    if ((vc % 2 == 1) && (hc % 2 == 1) && (vc < 4) && (hc < 8)) return word(vc / 2, hc / 2, tag);
    return 13'h1555;
  endfunction

  function automatic int vo_of(input int v);
    return (v < 2) ? v + 5 : v - 2;
  endfunction

  task automatic cyc(input logic en, input logic [PW-1:0] pix, input logic rst);
    n_rst     = rst;
    in_enable = en;
    in_pixels = pix;
    in_vcnt   = 3'(vc);
    in_hcnt   = 4'(hc);
    @(posedge clock);
    #1;
    o_en  = out_enable;
    o_pix = out_pixels;
    o_v   = out_vcnt;
    o_h   = out_hcnt;
    pv = vc;
    ph = hc;
    hc++;
    if (hc == 10) begin
      hc = 0;
      vc = (vc == 6) ? 0 : vc + 1;
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 20; k++) begin
      cyc(1'b1, src(0), 1'b1);
      checks++;
      if (o_en !== 1'b0 || o_pix !== '0 || o_v !== '0 || o_h !== '0) begin
        errors++;
        $display("FAIL reset @%0d,%0d got en=%b pix=%h v=%0d h=%0d want all 0", pv, ph, o_en, o_pix, o_v, o_h);
      end
    end
  endtask

  task automatic test_first_frame();
    for (int k = 0; k < 50; k++) begin
      logic          ee;
      logic [PW-1:0] ep;
      cyc(1'b1, src(0), 1'b0);
      ee = (vo_of(pv) == 2 || vo_of(pv) == 3) && ph < 8;
      ep = ee ? word(1, ph / 2, 0) : '0;
      checks++;
      if (o_en !== ee || o_pix !== ep) begin
        errors++;
        $display("FAIL first_frame @%0d,%0d got en=%b pix=%h want en=%b pix=%h", pv, ph, o_en, o_pix, ee, ep);
      end
      checks++;
      if (o_v !== 3'(vo_of(pv)) || o_h !== 4'(ph)) begin
        errors++;
        $display("FAIL first_frame_cnt @%0d,%0d got v=%0d h=%0d want v=%0d h=%0d", pv, ph, o_v, o_h, vo_of(pv), ph);
      end
    end
  endtask

  task automatic test_full_frame();
    for (int k = 0; k < 70; k++) begin
      logic          ee;
      logic [PW-1:0] ep;
      int            vo;
      cyc(1'b1, src(0), 1'b0);
      vo = vo_of(pv);
      ee = vo < 4 && ph < 8;
      ep = ee ? word(vo / 2, ph / 2, 0) : '0;
      checks++;
      if (o_en !== ee || o_pix !== ep || o_v !== 3'(vo) || o_h !== 4'(ph)) begin
        errors++;
        $display("FAIL full_frame @%0d,%0d got en=%b pix=%h v=%0d h=%0d want en=%b pix=%h v=%0d h=%0d",
                 pv, ph, o_en, o_pix, o_v, o_h, ee, ep, vo, ph);
      end
      if ((pv == 2 || pv == 3) && ph < 2) begin
        checks++;
        if (o_pix !== 13'h0000) begin
          errors++;
          $display("FAIL block00 @%0d,%0d got %h want 0000", pv, ph, o_pix);
        end
      end
      if ((pv == 4 || pv == 5) && (ph == 6 || ph == 7)) begin
        checks++;
        if (o_pix !== 13'h0103) begin
          errors++;
          $display("FAIL block13 @%0d,%0d got %h want 0103", pv, ph, o_pix);
        end
      end
    end
  endtask

  task automatic test_wrap_and_stale();
    for (int k = 0; k < 70; k++) begin
      logic          ee;
      logic [PW-1:0] ep;
      int            vo;
      cyc(!(vc == 3 && hc % 2 == 1), src(13'h040), 1'b0);
      vo = vo_of(pv);
      ee = vo < 4 && ph < 8;
      ep = ee ? word(vo / 2, ph / 2, (vo / 2 == 0) ? 13'h040 : 0) : '0;
      checks++;
      if (o_en !== ee || o_pix !== ep) begin
        errors++;
        $display("FAIL stale @%0d,%0d got en=%b pix=%h want en=%b pix=%h", pv, ph, o_en, o_pix, ee, ep);
      end
      if (pv < 2 && ph == 0) begin
        checks++;
        if (o_v !== 3'(pv + 5)) begin
          errors++;
          $display("FAIL wrap @%0d got out_vcnt=%0d want %0d", pv, o_v, pv + 5);
        end
      end
    end
  endtask

  task automatic test_midrow_reset();
    for (int k = 0; k < 70; k++) begin
      logic          ee;
      logic [PW-1:0] ep;
      int            vo;
      logic          rst_now;
      rst_now = (vc == 3 && hc == 4);
      cyc(1'b1, src(13'h020), rst_now);
      vo = vo_of(pv);
      if (pv == 3 && ph == 4) begin
        checks++;
        if (o_en !== 1'b0 || o_pix !== '0 || o_v !== '0 || o_h !== '0) begin
          errors++;
          $display("FAIL midrow_reset got en=%b pix=%h v=%0d h=%0d want all 0", o_en, o_pix, o_v, o_h);
        end
      end else begin
        ee = ph < 8 && (pv == 2 || (pv == 3 && ph < 4));
        ep = ee ? word(0, ph / 2, 13'h020) : '0;
        checks++;
        if (o_en !== ee || o_pix !== ep || o_v !== 3'(vo) || o_h !== 4'(ph)) begin
          errors++;
          $display("FAIL after_reset @%0d,%0d got en=%b pix=%h v=%0d h=%0d want en=%b pix=%h v=%0d h=%0d",
                   pv, ph, o_en, o_pix, o_v, o_h, ee, ep, vo, ph);
        end
      end
    end
  endtask

  task automatic test_extremes();
    for (int k = 0; k < 70; k++) begin
      logic          ee;
      logic [PW-1:0] ep;
      logic [PW-1:0] pix;
      int            vo;
      pix = src(0);
      if (vc == 1 && hc == 1) pix = 13'h1000;
      if (vc == 1 && hc == 7) pix = 13'h0FFF;
      cyc(1'b1, pix, 1'b0);
      vo = vo_of(pv);
      ee = vo < 4 && ph < 8;
      if (!ee) ep = '0;
      else if (vo / 2 == 0 && ph / 2 == 0) ep = 13'h1000;
      else if (vo / 2 == 0 && ph / 2 == 3) ep = 13'h0FFF;
      else ep = word(vo / 2, ph / 2, 0);
      checks++;
      if (o_en !== ee || o_pix !== ep) begin
        errors++;
        $display("FAIL extremes @%0d,%0d got en=%b pix=%h want en=%b pix=%h", pv, ph, o_en, o_pix, ee, ep);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_full_frame();
    test_wrap_and_stale();
    test_midrow_reset();
    test_extremes();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/unpool.md
# unpool

Nearest-neighbour 2x2 unpooling stage for the fixed-point feature stream. Consumes the pooled feature stream, where a pooled sample is valid once per 2x2 block at the block's odd/odd position of the full-resolution raster. Re-emits every sample on all four full-resolution positions of its block, with regenerated counters, two rows later. Its output is the low-resolution branch that is concatenated with the skip features to form the 2n-unit input of the integration network.

## Interface
- HEIGHT, -1: active image height; even.
- WIDTH, -1: active image width; even.
- W_HEIGHT, -1: raster height including blanking; must satisfy W_HEIGHT >= HEIGHT+2.
- W_WIDTH, -1: raster width including blanking; must satisfy W_WIDTH > WIDTH.
- UNITS, 12: feature units per pixel.
- INT_BITW, 5: integer bits per unit, sign included.
- FRAC_BITW, 8: fraction bits per unit.
- Derived: FIXED_BITW = INT_BITW+FRAC_BITW; V_BITW = log2(W_HEIGHT); H_BITW = log2(W_WIDTH), where log2 is ceil-log2.

Ports:
- clock  in  1  sole clock, rising edge.
- n_rst  in  1  reset; synchronous, active-high (1 = reset).
- in_enable  in  1  input pixel valid.
- in_pixels  in  [0:FIXED_BITW*UNITS-1]  pooled features; unit 0 at MSB end.
- in_vcnt  in  V_BITW  input row; advances every cycle across the full raster.
- in_hcnt  in  H_BITW  input column.
- out_enable  out  1  output pixel valid.
- out_pixels  out  [0:FIXED_BITW*UNITS-1]  unpooled features.
- out_vcnt  out  V_BITW  output row.
- out_hcnt  out  H_BITW  output column.

## Operation
- Write condition: in_enable=1, in_vcnt[0]=1, in_hcnt[0]=1, in_vcnt<HEIGHT, in_hcnt<WIDTH.
  - Block row i = in_vcnt>>1; block column j = in_hcnt>>1.
  - Write in_pixels to bank i[0], address j.
- Buffer: two banks (ping-pong on block-row parity), each WIDTH/2 words of FIXED_BITW*UNITS bits.
- Read side: output coordinate vo = (in_vcnt-2) mod W_HEIGHT, ho = in_hcnt.
  - Read bank (vo>>1)[0], address ho>>1.
  - A write and a read never target the same bank in the same cycle. No bypass is needed.
- Bank validity flags valid[1:0]:
  - Cleared by reset.
  - A flag arms on a write with j=0.
  - The bank's flag is set on the write with j=WIDTH/2-1, only if armed since reset.
  - A row that is partial because of a mid-row reset never validates its bank.
- out_enable = 1 when vo<HEIGHT, ho<WIDTH and valid[(vo>>1)[0]] are all true; otherwise 0.
- out_pixels = buffer data when out_enable=1; otherwise 0.
- No arithmetic on data: samples are copied bit-exact, with no saturation or rounding.
- Counter wrap: vo computed as in_vcnt+W_HEIGHT-2 for in_vcnt<2; otherwise in_vcnt-2.
- Reset mid-frame:
  - All outputs forced to reset values on the next edge, and valid is cleared.
  - Output stays disabled until a complete block row has been written after reset.

## Timing
- Reset values: out_enable=0, out_pixels=0, out_vcnt=0, out_hcnt=0.
- Pipeline:
  - Stage 0: address and bank computation from the input counters, plus the RAM read.
  - Stage 1: registered outputs.
- Latency from input counters to output counters: out_vcnt(t+1) = vo(t), out_hcnt(t+1) = in_hcnt(t).
- Sample timing:
  - The sample for block (i,j) is written at input position (2i+1, 2j+1).
  - It is emitted at output positions (2i..2i+1, 2j..2j+1).
  - These occur at input rows 2i+2 and 2i+3, plus one cycle.
- The first valid output after reset appears two input rows after the first complete block row.
- The output stream is continuous; there is no backpressure.

## Structure
- Shared header holds:
  - the log2 function;
  - FIXED_BITW derivation;
  - the packed-unit slicing macro shared with the layer blocks.
- Sub-module unpool_buf: simple dual-port RAM.
  - One write port and one read port with registered read.
  - Instantiated once per bank.
  - Parameters: DEPTH=WIDTH/2, BIT_WIDTH=FIXED_BITW*UNITS.
- Top level contains the write decode, the vo/bank computation, the valid flags and the output registers.

## Test plan
Bench configuration: WIDTH=8, HEIGHT=4, W_WIDTH=10, W_HEIGHT=7, UNITS=1.
- Full frame with sample = {i,j} at each odd/odd position -> in the second frame, out (0..1, 0..1) = 0x0000, out (2..3, 6..7) = 0x0103, each word repeated on all four positions.
- First frame after reset -> out_enable=0 through output rows 0-1. Output row 2 is the first enabled row, at the cycle after in_vcnt=4, in_hcnt=0.
- Counter wrap -> out_vcnt = 5 when in_vcnt = 0, and out_vcnt = 6 when in_vcnt = 1, one cycle later. out_enable = 0 in blanking rows and columns (vo>=4 or ho>=8).
- in_enable=0 at the odd/odd positions of block row 1 in frame 1 -> bank 1 holds frame-0 data for that row. Output reflects the previous contents; out_enable remains 1 once valid[1] is set.
- n_rst=1 for one cycle mid-row 3 (in_hcnt=4) -> all outputs 0 on the next edge.
  - Block row 1 remains unvalidated, so output rows 2-3 in that frame have out_enable=0.
  - Output rows 0-1 of the next frame are enabled.
- Extremes: samples 0x1000 and 0x0FFF -> reproduced bit-exact, with no sign change.
